// File: rtl/lcd_bus_reader.sv
// Read-side controller for the HD44780 8-bit bus: timed RW=1 read cycles,
// single reads over valid/ready and an autonomous busy-flag poll.
module lcd_bus_reader #(
    parameter int unsigned AS_CYCLES = 2,
    parameter int unsigned EH_CYCLES = 13,
    parameter int unsigned EL_CYCLES = 13,
    parameter int unsigned POLL_MAX  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    output logic       req_ready,
    input  logic       poll_start,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       poll_done,
    output logic       poll_timeout,
    output logic       bus_busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_d_i
);

    localparam int unsigned MAX_PHASE =
        (AS_CYCLES > EH_CYCLES) ? ((AS_CYCLES > EL_CYCLES) ? AS_CYCLES : EL_CYCLES)
                                : ((EH_CYCLES > EL_CYCLES) ? EH_CYCLES : EL_CYCLES);
    localparam int unsigned TW = $clog2(MAX_PHASE + 1);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        RECOVER
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] poll_cnt;
    logic          polling;
    logic          last_read;
    logic [CW-1:0] poll_cnt_nxt;

    assign poll_cnt_nxt = poll_cnt + CW'(1);

    // Phase sequencer; all bus and handshake outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            poll_cnt     <= '0;
            polling      <= 1'b0;
            last_read    <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            poll_done    <= 1'b0;
            poll_timeout <= 1'b0;
            bus_busy     <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_rw       <= 1'b0;
            lcd_e        <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            poll_done    <= 1'b0;
            poll_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (poll_start || req_valid) begin
                        // Poll wins a same-cycle tie and always reads BF/AC.
                        lcd_rs    <= poll_start ? 1'b0 : req_rs;
                        polling   <= poll_start;
                        lcd_rw    <= 1'b1;
                        bus_busy  <= 1'b1;
                        req_ready <= 1'b0;
                        timer     <= '0;
                        poll_cnt  <= '0;
                        last_read <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (timer == TW'(AS_CYCLES - 1)) begin
                        timer <= '0;
                        lcd_e <= 1'b1;
                        state <= ENABLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ENABLE: begin
                    if (timer == TW'(EH_CYCLES - 1)) begin
                        timer    <= '0;
                        lcd_e    <= 1'b0;
                        rsp_data <= lcd_d_i;
                        state    <= RECOVER;
                        if (polling) begin
                            poll_cnt <= poll_cnt_nxt;
                            if (!lcd_d_i[7]) begin
                                poll_done <= 1'b1;
                                last_read <= 1'b1;
                            end else if (poll_cnt_nxt == CW'(POLL_MAX)) begin
                                poll_timeout <= 1'b1;
                                last_read    <= 1'b1;
                            end
                        end else begin
                            rsp_valid <= 1'b1;
                            last_read <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                RECOVER: begin
                    if (timer == TW'(EL_CYCLES - 1)) begin
                        timer <= '0;
                        if (last_read) begin
                            lcd_rw    <= 1'b0;
                            lcd_rs    <= 1'b0;
                            bus_busy  <= 1'b0;
                            req_ready <= 1'b1;
                            polling   <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= SETUP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomized bench for lcd_bus_reader; expected waveforms come from the
// documented cycle offsets and busy-flag rules, evaluated per cycle.
module tb_lcd_bus_reader;

    localparam int AS     = 2;
    localparam int EH     = 13;
    localparam int EL     = 13;
    localparam int PMAX   = 4;
    localparam int PERIOD = AS + EH + EL;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_rs;
    logic       req_ready;
    logic       poll_start;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       poll_done;
    logic       poll_timeout;
    logic       bus_busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_d_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rd_data [0:7];
    bit         pre_zero = 1'b0;

    lcd_bus_reader #(
        .AS_CYCLES(AS),
        .EH_CYCLES(EH),
        .EL_CYCLES(EL),
        .POLL_MAX (PMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rs      (req_rs),
        .req_ready   (req_ready),
        .poll_start  (poll_start),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .poll_done   (poll_done),
        .poll_timeout(poll_timeout),
        .bus_busy    (bus_busy),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_d_i     (lcd_d_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Number of E pulses a transaction should produce.
    function automatic int exp_reads(input bit is_poll);
        if (!is_poll) return 1;
        for (int r = 0; r < PMAX; r++)
            if (!rd_data[r][7]) return r + 1;
        return PMAX;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_e"}, 32'(lcd_e), 0);
        check({tag, "_ready"}, 32'(req_ready), 1);
        check({tag, "_busy"}, 32'(bus_busy), 0);
        check({tag, "_flags"}, {29'd0, rsp_valid, poll_done, poll_timeout}, 0);
    endtask

    // Called #1 after a clock edge with inputs idle; returns the same way.
    task automatic run_txn(input bit is_poll, input bit rs, input bit both,
                           input bit noise, input int abort_at);
        int  nreads, end_k, r, p, pe;
        bit  in_e, busy, is_sample, last, timed_out, exp_rs;
        nreads    = exp_reads(is_poll);
        end_k     = nreads * PERIOD + 1;
        timed_out = is_poll && rd_data[nreads-1][7];
        exp_rs    = is_poll ? 1'b0 : rs;

        req_rs = rs;
        if (is_poll) begin
            poll_start = 1'b1;
            req_valid  = both;
        end else begin
            req_valid = 1'b1;
        end
        @(posedge clk); #1;
        poll_start = 1'b0;
        req_valid  = 1'b0;

        for (int k = 1; k <= end_k; k++) begin
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_e", 32'(lcd_e), 0);
                check("rst_busy", 32'(bus_busy), 0);
                check("rst_ready", 32'(req_ready), 1);
                check("rst_rw_rs", {30'd0, lcd_rw, lcd_rs}, 0);
                check("rst_data", 32'(rsp_data), 0);
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check("rst_flags", {29'd0, rsp_valid, poll_done, poll_timeout}, 0);
                    check("rst_e_hold", 32'(lcd_e), 0);
                end
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end

            r         = (k - 1) / PERIOD;
            p         = k - r * PERIOD;
            in_e      = (p >= AS + 1) && (p <= AS + EH);
            busy      = (k < end_k);
            is_sample = busy && (p == AS + EH + 1);
            last      = (r == nreads - 1);

            check("lcd_e", 32'(lcd_e), 32'(in_e));
            check("bus_busy", 32'(bus_busy), 32'(busy));
            check("req_ready", 32'(req_ready), 32'(!busy));
            check("lcd_rw", 32'(lcd_rw), 32'(busy));
            check("lcd_rs", 32'(lcd_rs), 32'(busy && exp_rs));
            check("rsp_valid", 32'(rsp_valid), 32'(is_sample && !is_poll));
            check("poll_done", 32'(poll_done), 32'(is_sample && is_poll && last && !timed_out));
            check("poll_timeout", 32'(poll_timeout), 32'(is_sample && is_poll && last && timed_out));
            if (is_sample) check("rsp_data", 32'(rsp_data), 32'(rd_data[r]));

            // Valid data appears only late in the E-high window.
            if (in_e) begin
                pe = p - AS;
                if (pe >= 10)     lcd_d_i = rd_data[r];
                else if (pre_zero) lcd_d_i = 8'h00;
                else              lcd_d_i = 8'($urandom);
            end else begin
                lcd_d_i = 8'($urandom);
            end

            if (noise && busy) begin
                req_valid  = 1'($urandom_range(0, 1));
                poll_start = 1'($urandom_range(0, 1));
                req_rs     = 1'($urandom_range(0, 1));
            end else begin
                req_valid  = 1'b0;
                poll_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check_idle("post");
    endtask

    task automatic fill_poll(input int nbf);
        for (int i = 0; i < 8; i++)
            rd_data[i] = (i < nbf) ? (8'h80 | 8'($urandom)) : (8'($urandom) & 8'h7F);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_rs     = 1'b0;
        poll_start = 1'b0;
        lcd_d_i    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_rw_rs", {30'd0, lcd_rw, lcd_rs}, 0);
        check("reset_data", 32'(rsp_data), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        rd_data[0] = 8'h8A;
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 0);

        pre_zero   = 1'b1;
        rd_data[0] = 8'h41;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 0);
        pre_zero   = 1'b0;

        fill_poll(3);
        rd_data[3] = 8'h05;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 8; i++) rd_data[i] = 8'h80;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 0);

        fill_poll(1);
        rd_data[1] = 8'h2C;
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 0);

        rd_data[0] = 8'($urandom);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 8);
        check_idle("after_abort");

        rd_data[0] = 8'h3C;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            bit is_poll;
            is_poll = 1'($urandom_range(0, 1));
            if (is_poll) fill_poll(int'($urandom_range(0, 5)));
            else rd_data[0] = 8'($urandom);
            run_txn(is_poll, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check_idle("gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side controller for the DE1-SoC HD44780 character LCD 8-bit bus, complementing the PicoBlaze LCD writer path. It issues HD44780 read cycles (RW=1) with setup, enable-pulse and recovery timing derived from cycle-count parameters sized for the 25 MHz system clock. It returns either the busy flag and address counter (RS=0) or DDRAM/CGRAM data (RS=1) over a valid/ready handshake. An autonomous busy-poll mode lets the writer side wait on the LCD without fixed delays.

## Interface
- AS_CYCLES, 2, clock cycles RS/RW are stable before E rises (≥60 ns at 25 MHz)
- EH_CYCLES, 13, clock cycles E is held high (≥450 ns); must be ≥10 so data is valid (tDDR 360 ns) at sampling
- EL_CYCLES, 13, clock cycles E is held low after a read before the next may start
- POLL_MAX, 255, maximum busy-flag reads in one poll before timeout (1..255)
- clk  in  1  system clock (CLK_25 domain)
- reset  in  1  asynchronous, active-low
- req_valid  in  1  single-read request
- req_rs  in  1  register select for the request: 0 = busy flag/AC, 1 = data
- req_ready  out  1  high only in IDLE with no poll pending
- poll_start  in  1  one-cycle pulse: start busy poll; accepted only when req_ready=1
- rsp_valid  out  1  one-cycle pulse, single-read result on rsp_data
- rsp_data  out  8  last sampled LCD byte, held until the next sample
- poll_done  out  1  one-cycle pulse: BF read as 0
- poll_timeout  out  1  one-cycle pulse: POLL_MAX reads all returned BF=1
- bus_busy  out  1  high from request acceptance until the end of recovery; writer must not drive the bus
- lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control lines
- lcd_d_i  in  8  LCD data bus input (top-level tristate released while bus_busy=1)

## Operation
- States: IDLE, SETUP, ENABLE, RECOVER. All outputs are registered.
- Reset values: lcd_e=0, lcd_rw=0, lcd_rs=0, req_ready=1, bus_busy=0, rsp_valid=0, poll_done=0, poll_timeout=0, rsp_data=8'h00, state IDLE, poll counter 0.
- IDLE:
  - poll_start has priority over req_valid if both are asserted in the same cycle.
  - On acceptance: latch RS (0 for a poll), drive lcd_rw=1, set bus_busy=1, go to SETUP.
- SETUP: lcd_e=0 for AS_CYCLES, then go to ENABLE.
- ENABLE:
  - lcd_e=1 for EH_CYCLES.
  - lcd_d_i is sampled into rsp_data on the clock edge that ends the last E-high cycle; lcd_e falls on that same edge.
  - Go to RECOVER.
- RECOVER:
  - lcd_e=0 and lcd_rw=1 held for EL_CYCLES.
  - Single read: then IDLE, with lcd_rw=0, lcd_rs=0, bus_busy=0, req_ready=1.
  - Poll, with the count incremented per sample:
    - if sampled bit7=0, poll_done pulses on the sample edge, and the block returns to IDLE after recovery;
    - else if count=POLL_MAX, poll_timeout pulses on the sample edge, and the block returns to IDLE after recovery;
    - otherwise go to SETUP for the next read (bus_busy stays high).
- rsp_valid pulses only for single reads, never during a poll. rsp_data updates on every sample, including poll reads.
- Requests arriving while req_ready=0 are ignored (not queued).
- The block never drives lcd_d.

## Timing
- Request accepted at edge N. Cycles are counted after that edge; defaults shown in brackets.
- lcd_rs/lcd_rw are valid from cycle N+1.
- lcd_e is high for cycles N+AS+1 .. N+AS+EH [N+3..N+15].
- Sample and rsp_valid/poll_done/poll_timeout appear in cycle N+AS+EH+1 [N+16].
- req_ready returns in cycle N+AS+EH+EL+1 [N+29].
- Poll read period: AS+EH+EL cycles [28 = 1.12 µs].
- Asynchronous reset mid-transaction:
  - lcd_e drops immediately (no minimum pulse honoured) and all outputs take their reset values.
  - No rsp_valid, poll_done or poll_timeout pulse is produced for the aborted read.
- Flag pulses are exactly one cycle wide; the next acceptance cannot occur before the cycle after req_ready=1.

## Test plan
- Single read, RS=0, lcd_d_i=8'h8A -> lcd_e high cycles N+3..N+15, rsp_valid in N+16 only, rsp_data=8'h8A, req_ready=1 at N+29, lcd_rw=1 throughout the busy window.
- Single read, RS=1, lcd_d_i changes from 8'h00 to 8'h41 during E-high cycle 10 -> rsp_data=8'h41, lcd_rs=1 from N+1 to N+28.
- Poll with BF=1 for 3 reads then lcd_d_i=8'h05 -> 4 E pulses 28 cycles apart, poll_done single pulse, rsp_data=8'h05, no rsp_valid.
- Poll with POLL_MAX=4 and BF stuck at 1 (8'h80) -> exactly 4 E pulses, poll_timeout pulse on the 4th sample, no poll_done.
- Same-cycle poll_start and req_valid, then req_valid while busy -> poll executed; the mid-busy request is ignored and produces no extra E pulse.
- reset asserted at N+8 during E high -> lcd_e=0 and bus_busy=0 combinationally, no response pulse; after release a new read completes normally.
